// File: rtl/inst_fetch_sync.sv
// Instruction-fetch reader: owns the PC, reads a 1-cycle sync ROM, realigns each word with its PC.
// Latency: read issued in cycle n, ROM data in n+1, registered instruction on inst_o in n+2.
// Backpressure: stall_i stops issue and freezes outputs; the one word in flight parks in a hold buffer.
module inst_fetch_sync #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [31:0]       inst_pc_o
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_pc_q, rsp_pc_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_dat_q, hold_dat_d;
  logic [31:0]         hold_pc_q, hold_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0]   inst_dat_q, inst_dat_d;
  logic [31:0]         inst_pc_q, inst_pc_d;
  logic                issue;

  // A read goes out only when running, downstream is ready and no redirect is pending.
  always_comb begin
    issue = (state_q == RUN) & ~stall_i & ~branch_i;
  end

  assign rom_ce_o     = issue;
  assign rom_addr_o   = pc_q[ADDR_W+1:2];
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_dat_q;
  assign inst_pc_o    = inst_pc_q;

  // Next state: a single boot cycle with no read, then run until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end
  end

  // PC and in-flight response tracking; a redirect overrides everything and drops the in-flight word.
  always_comb begin
    pc_d        = pc_q;
    rsp_valid_d = issue;
    rsp_pc_d    = rsp_pc_q;
    if (branch_i) begin
      pc_d = branch_target_i & ~32'd3;
    end else if (issue) begin
      pc_d     = pc_q + 32'd4;
      rsp_pc_d = pc_q;
    end
  end

  // Output register and hold buffer: park the returning word while stalled, drain the buffer first on resume.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_dat_d   = hold_dat_q;
    hold_pc_d    = hold_pc_q;
    inst_valid_d = inst_valid_q;
    inst_dat_d   = inst_dat_q;
    inst_pc_d    = inst_pc_q;
    if (branch_i) begin
      hold_valid_d = 1'b0;
      inst_valid_d = 1'b0;
    end else if (stall_i) begin
      if (rsp_valid_q) begin
        hold_valid_d = 1'b1;
        hold_dat_d   = rom_data_i;
        hold_pc_d    = rsp_pc_q;
      end
    end else begin
      inst_valid_d = hold_valid_q | rsp_valid_q;
      hold_valid_d = 1'b0;
      if (hold_valid_q) begin
        inst_dat_d = hold_dat_q;
        inst_pc_d  = hold_pc_q;
      end else if (rsp_valid_q) begin
        inst_dat_d = rom_data_i;
        inst_pc_d  = rsp_pc_q;
      end
    end
  end

  // State registers; reset clears everything at once, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_dat_q   <= '0;
      hold_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_dat_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_dat_q   <= hold_dat_d;
      hold_pc_q    <= hold_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_dat_q   <= inst_dat_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_sync.sv
// Bench for inst_fetch_sync: directed cycle table, async reset mid-stall, random stall/branch stream.
// Latency: n/a (testbench).
// Backpressure: drives stall_i randomly and checks the consumed instruction stream.
module tb_inst_fetch_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [9:0]  rom_addr_o;
  logic [31:0] rom_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int total = 0;
  int bad   = 0;

  inst_fetch_sync #(.ADDR_W(10), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o)
  );

  always #5 clk = ~clk;

  // Program ROM: 1-cycle synchronous read, mem[k] = A0000000 + k.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= 32'hA000_0000 + {22'd0, rom_addr_o};
  end

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] tgt;
    logic        ce;
    logic [9:0]  addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[31];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'hA000_0000 + {22'd0, pc[11:2]};
  endfunction

  task automatic setv(input int i, input logic s, input logic b, input logic [31:0] tgt,
                      input logic ce, input int addr, input logic v, input logic [31:0] pc);
    tbl[i].s = s; tbl[i].b = b; tbl[i].tgt = tgt; tbl[i].ce = ce;
    tbl[i].addr = addr[9:0]; tbl[i].v = v; tbl[i].pc = pc;
  endtask

  // Called at posedge+1: drive one table row, check mid-cycle, advance to next posedge+1.
  task automatic apply_vec(input int i);
    stall_i = tbl[i].s; branch_i = tbl[i].b; branch_target_i = tbl[i].tgt;
    #4;
    chk($sformatf("tbl%0d_ce", i), rom_ce_o, tbl[i].ce);
    chk($sformatf("tbl%0d_addr", i), rom_addr_o, tbl[i].addr);
    chk($sformatf("tbl%0d_valid", i), inst_valid_o, tbl[i].v);
    if (tbl[i].v) begin
      chk($sformatf("tbl%0d_pc", i), inst_pc_o, tbl[i].pc);
      chk($sformatf("tbl%0d_inst", i), inst_o, rom_word(tbl[i].pc));
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, inst_valid_o, 0);
    chk({nm, "_inst"},  inst_o, 0);
    chk({nm, "_pc"},    inst_pc_o, 0);
    chk({nm, "_ce"},    rom_ce_o, 0);
    chk({nm, "_addr"},  rom_addr_o, 0);
  endtask

  initial begin
    logic        ps, pb, pv, iss, iss1, iss2, running;
    logic [31:0] pinst, ppc, exp_next;
    int          cyc, consumed;

    rst_n = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;

    // Cycle-by-cycle script from reset release: startup, 1- and 3-cycle stalls,
    // unstalled branch to 0x43, branch+stall to 0x100, branch to 0xFF8 with address wrap.
    setv(0, 0,0,0,        0,0,   0,0);
    setv(1, 0,0,0,        1,0,   0,0);
    setv(2, 0,0,0,        1,1,   0,0);
    setv(3, 0,0,0,        1,2,   1,32'h0);
    setv(4, 0,0,0,        1,3,   1,32'h4);
    setv(5, 1,0,0,        0,4,   1,32'h8);
    setv(6, 0,0,0,        1,4,   1,32'h8);
    setv(7, 0,0,0,        1,5,   1,32'hC);
    setv(8, 1,0,0,        0,6,   1,32'h10);
    setv(9, 1,0,0,        0,6,   1,32'h10);
    setv(10,1,0,0,        0,6,   1,32'h10);
    setv(11,0,0,0,        1,6,   1,32'h10);
    setv(12,0,0,0,        1,7,   1,32'h14);
    setv(13,0,0,0,        1,8,   1,32'h18);
    setv(14,0,0,0,        1,9,   1,32'h1C);
    setv(15,0,1,32'h43,   0,10,  1,32'h20);
    setv(16,0,0,0,        1,16,  0,0);
    setv(17,0,0,0,        1,17,  0,0);
    setv(18,0,0,0,        1,18,  1,32'h40);
    setv(19,1,1,32'h100,  0,19,  1,32'h44);
    setv(20,1,0,0,        0,64,  0,0);
    setv(21,1,0,0,        0,64,  0,0);
    setv(22,0,0,0,        1,64,  0,0);
    setv(23,0,0,0,        1,65,  0,0);
    setv(24,0,0,0,        1,66,  1,32'h100);
    setv(25,0,1,32'hFF8,  0,67,  1,32'h104);
    setv(26,0,0,0,        1,1022,0,0);
    setv(27,0,0,0,        1,1023,0,0);
    setv(28,0,0,0,        1,0,   1,32'hFF8);
    setv(29,0,0,0,        1,1,   1,32'hFFC);
    setv(30,0,0,0,        1,2,   1,32'h1000);

    repeat (2) @(posedge clk);
    #5;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) apply_vec(i);

    // Stall so the in-flight word parks in the hold buffer, then reset asynchronously.
    stall_i = 1'b1; branch_i = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply_vec(i);

    // Random stall/branch stream checked against a stream-level model:
    // consumed words (valid & ~stall) must follow RESET_PC, +4, ..., restarting at each branch target.
    rst_n = 1'b0; stall_i = 1'b0; branch_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ps = 0; pb = 0; pv = 0; iss1 = 0; iss2 = 0; pinst = '0; ppc = '0;
    exp_next = 32'h0; consumed = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      stall_i  = ($urandom_range(0, 99) < 30);
      branch_i = ($urandom_range(0, 99) < 6);
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFF0 + $urandom_range(0, 15)) : $urandom;
      #4;
      running = (cyc >= 1);
      iss = running && !stall_i && !branch_i;
      chk("rnd_ce", rom_ce_o, iss);
      if (pb) chk("rnd_flush", inst_valid_o, 0);
      if (ps && !pb) begin
        chk("rnd_freeze_valid", inst_valid_o, pv);
        chk("rnd_freeze_pc", inst_pc_o, ppc);
        chk("rnd_freeze_inst", inst_o, pinst);
      end
      if (iss2 && !ps && !pb) chk("rnd_thru", inst_valid_o, 1);
      if (inst_valid_o && !stall_i) begin
        chk("rnd_pc", inst_pc_o, exp_next);
        chk("rnd_inst", inst_o, rom_word(exp_next));
        exp_next = exp_next + 32'd4;
        consumed++;
      end
      if (branch_i) exp_next = branch_target_i & ~32'd3;
      iss2 = iss1; iss1 = iss;
      ps = stall_i; pb = branch_i;
      pv = inst_valid_o; ppc = inst_pc_o; pinst = inst_o;
      @(posedge clk); #1;
    end
    chk("rnd_progress", (consumed > 1000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
